// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the 111010 stream detector slice.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [5:0] DEFAULT_PATTERN = 6'b111010;
  localparam int         DEFAULT_PLEN    = 6;

endpackage

// File: rtl/pattern_det_mealy.sv
// Serial Mealy overlapping pattern detector: history shift register plus fill counter.
module pattern_det_mealy
  import seq_det_pkg::*;
#(
  parameter int             PLEN    = DEFAULT_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic bit_in,
  input  logic bit_vld,
  output logic det
);

  localparam int             FW   = $clog2(PLEN);
  localparam logic [FW-1:0]  FULL = FW'(PLEN - 1);

  logic [PLEN-2:0] hist;
  logic [FW-1:0]   fill;
  logic [PLEN-1:0] window;

  // Oldest consumed bit lands in the MSB, matching PATTERN's first-in-time order.
  assign window = {hist, bit_in};
  assign det    = bit_vld && (fill == FULL) && (window == PATTERN);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_vld) begin
      hist <= window[PLEN-2:0];
      if (fill != FULL) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-bit stream controller around pattern_det_mealy with saturating hit count and sticky irq.
module seq_det_stream_ctrl
  import seq_det_pkg::*;
#(
  parameter int              W       = 8,
  parameter int              CW      = 8,
  parameter int              PLEN    = DEFAULT_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [CW-1:0] threshold,
  input  logic          irq_ack,
  output logic          ser_bit,
  output logic          ser_vld,
  output logic          hit,
  output logic [CW-1:0] hit_cnt,
  output logic          irq,
  output logic          busy
);

  localparam int            IW   = $clog2(W);
  localparam logic [CW-1:0] CMAX = '1;

  state_t        state;
  logic [W-1:0]  sreg;
  logic [IW-1:0] idx;
  logic          live, active, last, take, det;
  logic [CW-1:0] cnt_inc;

  // Handshake: a word moves on the edge where din_valid && din_ready; din_ready is
  // high only when en=1 and the serializer is empty or presenting its final bit.
  assign live      = rst && !clr;
  assign active    = (state != IDLE);
  assign last      = active && (idx == '0);
  assign din_ready = live && en && (!active || last);
  assign take      = din_ready && din_valid;
  // PAUSE is only bookkeeping: any cycle with en=1 and a word in flight consumes a bit.
  assign ser_vld   = live && en && active;
  assign ser_bit   = sreg[W-1];
  assign busy      = active;
  assign cnt_inc   = hit_cnt + 1'b1;

  pattern_det_mealy #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk     (clk),
    .rst     (rst),
    .flush   (clr),
    .bit_in  (ser_bit),
    .bit_vld (ser_vld),
    .det     (det)
  );

  always_ff @(posedge clk) begin
    if (!live) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else if (take) begin
      state <= SHIFT;
      sreg  <= din;
      idx   <= IW'(W - 1);
    end else if (ser_vld) begin
      if (last) begin
        state <= IDLE;
      end else begin
        state <= SHIFT;
        sreg  <= {sreg[W-2:0], 1'b0};
        idx   <= idx - 1'b1;
      end
    end else if (active && !en) begin
      state <= PAUSE;
    end
  end

  // irq sets only on a real increment landing on threshold, so a saturated or
  // already-passed count never re-raises it; set beats a simultaneous ack.
  always_ff @(posedge clk) begin
    if (!live) begin
      hit     <= 1'b0;
      hit_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      hit <= det;
      if (det && hit_cnt != CMAX) hit_cnt <= cnt_inc;
      if (det && hit_cnt != CMAX && threshold != '0 && cnt_inc == threshold)
        irq <= 1'b1;
      else if (irq_ack)
        irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Randomized + directed scoreboard bench for seq_det_stream_ctrl (CW=8 and CW=3 instances).
module tb_seq_det_stream_ctrl;

  localparam int         W       = 8;
  localparam int         PLEN    = 6;
  localparam logic [5:0] PATTERN = 6'b111010;

  logic       clk, rst, en, clr, din_valid, irq_ack;
  logic [7:0] din;
  logic [7:0] thr8;
  logic [2:0] thr3;

  logic       din_ready, ser_bit, ser_vld, hit, irq, busy;
  logic [7:0] hit_cnt;
  logic       din_ready3, ser_bit3, ser_vld3, hit3, irq3, busy3;
  logic [2:0] hit_cnt3;

  seq_det_stream_ctrl #(.W(W), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .threshold(thr8), .irq_ack(irq_ack), .ser_bit(ser_bit),
    .ser_vld(ser_vld), .hit(hit), .hit_cnt(hit_cnt), .irq(irq), .busy(busy)
  );

  seq_det_stream_ctrl #(.W(W), .CW(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(din_ready3), .threshold(thr3), .irq_ack(irq_ack), .ser_bit(ser_bit3),
    .ser_vld(ser_vld3), .hit(hit3), .hit_cnt(hit_cnt3), .irq(irq3), .busy(busy3)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  m_word   = '0;
  int          m_left   = 0;
  bit          m_hist[$];
  int          m_cnt8   = 0;
  int          m_cnt3   = 0;
  bit          m_irq8   = 0;
  bit          m_irq3   = 0;
  bit          rand_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bump(input int cnt, input bit irq_in, input bit h, input int maxv,
                      input int thr, input bit ack, output int cnt_o, output bit irq_o);
    cnt_o = cnt;
    irq_o = ack ? 1'b0 : irq_in;
    if (h && cnt < maxv) begin
      cnt_o = cnt + 1;
      if (thr != 0 && cnt_o == thr) irq_o = 1'b1;
    end
  endtask

  // Model: each edge, consume one bit if a word is in flight and en=1; match the
  // last PLEN bits consumed since flush against PATTERN; expected hit shows next cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst || clr) begin
        m_left = 0;
        m_hist.delete();
        m_cnt8 = 0;
        m_cnt3 = 0;
        m_irq8 = 0;
        m_irq3 = 0;
      end else begin
        automatic int pre  = m_left;
        automatic bit rdy  = en && (pre <= 1);
        automatic bit hitv = 0;
        if (en && pre > 0) begin
          automatic bit b = m_word[pre-1];
          if (m_hist.size() == PLEN - 1) begin
            automatic int v = 0;
            foreach (m_hist[k]) v = (v << 1) | int'(m_hist[k]);
            v = (v << 1) | int'(b);
            hitv = (v == int'(PATTERN));
          end
          m_hist.push_back(b);
          if (m_hist.size() > PLEN - 1) void'(m_hist.pop_front());
          m_left = pre - 1;
        end
        bump(m_cnt8, m_irq8, hitv, 255, int'(thr8), irq_ack, m_cnt8, m_irq8);
        bump(m_cnt3, m_irq3, hitv, 7, int'(thr3), irq_ack, m_cnt3, m_irq3);
        if (hitv) exp_q.push_back(32'(cyc + 1));
        if (rdy && din_valid) begin
          m_word = din;
          m_left = W;
        end
      end
      cyc++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      begin
        automatic bit live    = rst && !clr;
        automatic bit exp_vld = live && en && (m_left > 0);
        automatic bit exp_rdy = live && en && (m_left <= 1);
        automatic bit exp_hit = (exp_q.size() > 0) && (exp_q[0] == 32'(cyc));
        chk("din_ready", din_ready, exp_rdy);
        chk("din_ready3", din_ready3, exp_rdy);
        chk("ser_vld", ser_vld, exp_vld);
        if (exp_vld) chk("ser_bit", ser_bit, m_word[m_left-1]);
        chk("busy", busy, m_left > 0);
        chk("busy3", busy3, m_left > 0);
        chk("hit", hit, exp_hit);
        chk("hit3", hit3, exp_hit);
        if (exp_hit) void'(exp_q.pop_front());
        chk("hit_cnt", hit_cnt, m_cnt8);
        chk("hit_cnt3", hit_cnt3, m_cnt3);
        chk("irq", irq, m_irq8);
        chk("irq3", irq3, m_irq3);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      en      = ($urandom_range(0, 5) != 0);
      irq_ack = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_word(input logic [7:0] w);
    bit ok = 0;
    din       = w;
    din_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    din_valid = 1'b0;
    chk("accept_timeout", ok, 1);
  endtask

  initial begin
    rst = 0; clr = 0; en = 1; din = '0; din_valid = 0; irq_ack = 0;
    thr8 = 8'd3; thr3 = 3'd5;
    idle(3);
    rst = 1;
    idle(2);

    // single word, one hit on bit 5
    send_word(8'b11101011); idle(10);
    // back-to-back words with a cross-word hit
    send_word(8'b00000111); send_word(8'b01000000); idle(10);
    // long 1-run, then a non-matching word
    send_word(8'b11111010); send_word(8'b10101010); idle(10);
    // pause three cycles mid-word
    send_word(8'b11101000); idle(2);
    en = 0; idle(3); en = 1; idle(12);
    // threshold/saturation: many consecutive hits, then ack
    repeat (10) send_word(8'b11101011);
    idle(10);
    irq_ack = 1; tick(); irq_ack = 0;
    send_word(8'b11101011); idle(10);
    // clr mid-word, then flushed history
    send_word(8'b11101011); idle(3);
    clr = 1; tick(); clr = 0;
    send_word(8'b01000000); idle(10);
    // same with reset
    send_word(8'b11101011); idle(3);
    rst = 0; tick(); rst = 1;
    send_word(8'b01000000); idle(10);

    // randomized phase
    rand_mode = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        thr8 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
        thr3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 39) == 0) begin
        clr = 1; tick(); clr = 0;
      end
      send_word(($urandom_range(0, 2) == 0) ? 8'b11101010 : 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_mode = 0;
    en = 1; irq_ack = 0;
    idle(20);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
